// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - hazard/forwarding controller: producer scoreboard, load-use stall, flush, halt drain
module hazard_fwd_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_halt,
  input  logic              br_mispred,
  input  logic              resume,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              fetch_en,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              halted
);

  localparam int CNT_W = $clog2(FWD_DEPTH + 2);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [FWD_DEPTH:0] r_vld, r_we, r_ld;
  logic [REG_AW-1:0] r_rd [0:FWD_DEPTH];
  logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2;

  logic w_run, w_flush, w_load_hit, w_issue, w_halt_acc;

  assign w_run   = (r_state == ST_RUN);
  assign w_flush = rst & w_run & br_mispred;

  // A load still inside its latency window cannot feed the instruction now in ID.
  always_comb begin
    w_load_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (r_vld[k] && r_we[k] && r_ld[k] &&
          ((id_rs1 != '0 && id_rs1 == r_rd[k]) || (id_rs2 != '0 && id_rs2 == r_rd[k])))
        w_load_hit = 1'b1;
    end
  end

  assign stall       = w_run & id_valid & w_load_hit & ~br_mispred;
  assign flush_id_ex = w_flush;
  assign flush_if_id = w_flush | ~w_run;
  assign fetch_en    = w_run & ~stall;
  assign halted      = (r_state == ST_HALTED);
  assign w_issue     = w_run & id_valid & ~stall & ~br_mispred;
  assign w_halt_acc  = w_issue & id_is_halt;

  // Scan oldest to youngest so the youngest eligible producer is the final assignment.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (r_vld[k] && r_we[k] && !(r_ld[k] && k <= LOAD_LAT)) begin
        if (r_ex_rs1 != '0 && r_rd[k] == r_ex_rs1) fwd_a_sel = SEL_W'(k);
        if (r_ex_rs2 != '0 && r_rd[k] == r_ex_rs2) fwd_b_sel = SEL_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_halt_acc) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_W'(FWD_DEPTH + 1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_HALTED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_vld    <= '0;
      r_we     <= '0;
      r_ld     <= '0;
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) r_rd[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_we[k]  <= r_we[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      // The halt occupies a slot so the drain can see it leave, but never writes.
      r_vld[0] <= w_issue;
      r_we[0]  <= w_issue & id_we & ~id_is_halt;
      r_ld[0]  <= w_issue & id_is_load & ~id_is_halt;
      r_rd[0]  <= w_issue ? id_rd : '0;
      r_ex_rs1 <= w_issue ? id_rs1 : '0;
      r_ex_rs2 <= w_issue ? id_rs2 : '0;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - random and directed checks of hazard_fwd_unit against a pipeline model
module tb_hazard_fwd_unit;

  localparam int RAW = 5;
  localparam int FD  = 2;
  localparam int LL  = 1;
  localparam int SW  = $clog2(FD + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid, id_we, id_is_load, id_is_halt, br_mispred, resume;
  logic [RAW-1:0] id_rs1, id_rs2, id_rd;
  logic           stall, flush_if_id, flush_id_ex, fetch_en, halted;
  logic [SW-1:0]  fwd_a_sel, fwd_b_sel;

  hazard_fwd_unit #(.REG_AW(RAW), .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .br_mispred(br_mispred), .resume(resume),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fetch_en(fetch_en), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vld;
    bit we;
    bit ld;
    bit hlt;
    int rd;
  } ent_t;

  ent_t pipe [FD+1];
  int   ex1, ex2;
  bit   m_drain, m_halted;
  int   m_stall;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int k = 0; k <= FD; k++) pipe[k] = '{0, 0, 0, 0, 0};
    ex1 = 0;
    ex2 = 0;
    m_drain  = 0;
    m_halted = 0;
  endfunction

  function automatic int youngest(input int rs);
    if (rs == 0) return 0;
    for (int k = 1; k <= FD; k++)
      if (pipe[k].vld && pipe[k].we && pipe[k].rd == rs && !(pipe[k].ld && k <= LL)) return k;
    return 0;
  endfunction

  task automatic compare();
    int e_fie, e_fii, e_fe, e_a, e_b, e_h;
    bit run, hit;
    run = !m_drain && !m_halted;
    hit = 0;
    for (int k = 0; k < LL; k++)
      if (pipe[k].vld && pipe[k].we && pipe[k].ld && pipe[k].rd != 0 &&
          (pipe[k].rd == int'(id_rs1) || pipe[k].rd == int'(id_rs2))) hit = 1;
    if (!rst_n) begin
      m_stall = 0; e_fie = 0; e_fii = 0; e_fe = 1; e_a = 0; e_b = 0; e_h = 0;
    end else begin
      m_stall = (run && id_valid && hit && !br_mispred) ? 1 : 0;
      e_fie   = (run && br_mispred) ? 1 : 0;
      e_fii   = (e_fie == 1 || !run) ? 1 : 0;
      e_fe    = (run && m_stall == 0) ? 1 : 0;
      e_a     = youngest(ex1);
      e_b     = youngest(ex2);
      e_h     = m_halted ? 1 : 0;
    end
    chk("stall",       int'(stall),       m_stall);
    chk("flush_id_ex", int'(flush_id_ex), e_fie);
    chk("flush_if_id", int'(flush_if_id), e_fii);
    chk("fetch_en",    int'(fetch_en),    e_fe);
    chk("fwd_a_sel",   int'(fwd_a_sel),   e_a);
    chk("fwd_b_sel",   int'(fwd_b_sel),   e_b);
    chk("halted",      int'(halted),      e_h);
  endtask

  function automatic void model_step();
    bit run, acc, hin;
    if (!rst_n) begin
      model_reset();
      return;
    end
    run = !m_drain && !m_halted;
    acc = run && id_valid && m_stall == 0 && !br_mispred;
    for (int k = FD; k >= 1; k--) pipe[k] = pipe[k-1];
    if (acc) pipe[0] = '{1, id_we && !id_is_halt, id_is_load && !id_is_halt, id_is_halt, int'(id_rd)};
    else     pipe[0] = '{0, 0, 0, 0, 0};
    ex1 = acc ? int'(id_rs1) : 0;
    ex2 = acc ? int'(id_rs2) : 0;
    hin = 0;
    for (int k = 0; k <= FD; k++) if (pipe[k].vld && pipe[k].hlt) hin = 1;
    if (acc && id_is_halt) m_drain = 1;
    else if (m_drain) begin
      if (!hin) begin
        m_drain  = 0;
        m_halted = 1;
      end
    end else if (m_halted && resume) m_halted = 0;
  endfunction

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit we, input bit ld, input bit hlt, input bit mis, input bit res);
    id_valid   = v;
    id_rs1     = RAW'(rs1);
    id_rs2     = RAW'(rs2);
    id_rd      = RAW'(rd);
    id_we      = we;
    id_is_load = ld;
    id_is_halt = hlt;
    br_mispred = mis;
    resume     = res;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample();
    #1;
    compare();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    m_stall = 0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    sample();
    chk("rst_fetch_en", int'(fetch_en), 1);
    chk("rst_halted",   int'(halted),   0);
    chk("rst_sel_a",    int'(fwd_a_sel), 0);
    advance();
    rst_n = 1'b1;
    sample(); advance();

    // back-to-back ALU dependency
    drive(1, 1, 2, 5, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 5, 5, 6, 1, 0, 0, 0, 0); sample(); advance();
    idle(); sample();
    chk("b2b_sel_a", int'(fwd_a_sel), 1);
    chk("b2b_sel_b", int'(fwd_b_sel), 1);
    chk("b2b_stall", int'(stall), 0);
    advance(); sample(); advance(); sample(); advance();

    // load-use: one bubble, then forward from entry 2
    drive(1, 1, 0, 7, 1, 1, 0, 0, 0); sample(); advance();
    drive(1, 7, 0, 8, 1, 0, 0, 0, 0); sample();
    chk("lu_stall", int'(stall), 1);
    chk("lu_fetch_en", int'(fetch_en), 0);
    advance();
    sample();
    chk("lu_stall_clear", int'(stall), 0);
    advance();
    idle(); sample();
    chk("lu_sel_a", int'(fwd_a_sel), 2);
    chk("lu_sel_b", int'(fwd_b_sel), 0);
    advance(); sample(); advance(); sample(); advance();

    // x0 writer never forwards; two writers of x9 -> youngest wins
    drive(1, 1, 1, 0, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 1, 2, 9, 1, 0, 0, 0, 0); sample();
    chk("x0_sel_a", int'(fwd_a_sel), 0);
    advance();
    drive(1, 3, 4, 9, 1, 0, 0, 0, 0); sample(); advance();
    drive(1, 9, 9, 10, 1, 0, 0, 0, 0); sample(); advance();
    idle(); sample();
    chk("young_sel_a", int'(fwd_a_sel), 1);
    advance(); sample(); advance(); sample(); advance();

    // mispredict during a load-use stall
    drive(1, 1, 0, 7, 1, 1, 0, 0, 0); sample(); advance();
    drive(1, 7, 0, 8, 1, 0, 0, 1, 0); sample();
    chk("mp_stall", int'(stall), 0);
    chk("mp_flush_if_id", int'(flush_if_id), 1);
    chk("mp_flush_id_ex", int'(flush_id_ex), 1);
    advance();
    drive(1, 7, 0, 8, 1, 0, 0, 0, 0); sample();
    chk("mp_next_stall", int'(stall), 0);
    chk("mp_next_sel_a", int'(fwd_a_sel), 0);
    advance();
    idle(); sample(); advance(); sample(); advance(); sample(); advance();

    // halt drain and resume
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); sample();
    chk("h_fetch_acc", int'(fetch_en), 1);
    advance();
    idle(); sample();
    chk("h_fetch_drain", int'(fetch_en), 0);
    chk("h_halted_d1", int'(halted), 0);
    advance(); sample(); advance(); sample();
    chk("h_halted_d3", int'(halted), 0);
    advance();
    resume = 1'b1; sample();
    chk("h_halted", int'(halted), 1);
    advance();
    idle(); sample();
    chk("h_resume_fetch", int'(fetch_en), 1);
    advance();

    // reset during drain
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); sample(); advance();
    idle(); rst_n = 1'b0; sample();
    chk("rd_halted", int'(halted), 0);
    chk("rd_fetch_en", int'(fetch_en), 1);
    chk("rd_sel_b", int'(fwd_b_sel), 0);
    advance();
    rst_n = 1'b1; sample(); advance();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 4), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      sample();
      advance();
    end
    rst_n = 1'b1;
    idle();
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
